// File: rtl/sm_mem_ctrl.sv
// sm_mem_ctrl: serialises one scheduler memory request covering N_CORES lanes
// onto a single-port data memory. Reads to a shared address may be merged into
// one access; read results come back through a tag pipeline that matches the
// memory read latency and scatter the returned word into every lane of the group.
module sm_mem_ctrl #(
  parameter int N_CORES  = 8,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int COALESCE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m_read,
  input  logic                      m_write,
  output logic                      m_ready,
  output logic                      busy,
  input  logic [N_CORES-1:0]        en_mask,
  input  logic [N_CORES*ADDR_W-1:0] core_addr,
  input  logic [N_CORES*DATA_W-1:0] core_wdata,
  output logic [N_CORES*DATA_W-1:0] core_rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_we,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int LANE_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Index of the lowest set bit of a lane mask (0 when the mask is empty).
  function automatic logic [LANE_W-1:0] lowest_lane(input logic [N_CORES-1:0] mask);
    logic [LANE_W-1:0] lane;
    logic              found;
    lane  = '0;
    found = 1'b0;
    for (int i = 0; i < N_CORES; i++) begin
      if (!found && mask[i]) begin
        lane  = LANE_W'(i);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return lane;
  endfunction

  // Extract one lane's address field from a packed lane vector.
  function automatic logic [ADDR_W-1:0] lane_addr(input logic [N_CORES*ADDR_W-1:0] vec,
                                                  input logic [LANE_W-1:0]         lane);
    return vec[int'(lane)*ADDR_W +: ADDR_W];
  endfunction

  // Extract one lane's data field from a packed lane vector.
  function automatic logic [DATA_W-1:0] lane_data(input logic [N_CORES*DATA_W-1:0] vec,
                                                  input logic [LANE_W-1:0]         lane);
    return vec[int'(lane)*DATA_W +: DATA_W];
  endfunction

  state_e                      state_q, state_d;
  logic [N_CORES-1:0]          pend_q, pend_d;
  logic [N_CORES*ADDR_W-1:0]   addr_q, addr_d;
  logic [N_CORES*DATA_W-1:0]   wdata_q, wdata_d;
  logic                        we_op_q, we_op_d;
  logic [LANE_W-1:0]           lane_q, lane_d;
  logic                        busy_q, m_ready_q;
  logic [ADDR_W-1:0]           mem_addr_q;
  logic [DATA_W-1:0]           mem_wdata_q;
  logic                        mem_we_q;
  logic [N_CORES-1:0]          tag_q [RD_LAT];
  logic [N_CORES*DATA_W-1:0]   core_rdata_q;

  logic [N_CORES-1:0]          lane_oh_s;
  logic [N_CORES-1:0]          match_s;
  logic [N_CORES-1:0]          group_s;
  logic [ADDR_W-1:0]           cur_addr_s;
  logic                        issue_rd_s;
  logic                        issue_next_s;
  logic                        upstream_busy_s;

  // Lanes served by the access currently on the memory port.
  always_comb begin
    lane_oh_s         = '0;
    lane_oh_s[lane_q] = 1'b1;
    cur_addr_s        = lane_addr(addr_q, lane_q);
    match_s           = '0;
    for (int i = 0; i < N_CORES; i++) begin
      match_s[i] = pend_q[i] & (addr_q[i*ADDR_W +: ADDR_W] == cur_addr_s);
    end
    if (we_op_q || (COALESCE == 0)) begin
      group_s = lane_oh_s;
    end else begin
      group_s = match_s;
    end
  end

  // Any read group still short of the pipeline's last stage.
  always_comb begin
    upstream_busy_s = 1'b0;
    for (int s = 0; s < RD_LAT - 1; s++) begin
      upstream_busy_s = upstream_busy_s | (|tag_q[s]);
    end
  end

  // Next-state, request capture and selection of the next lane to issue.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_op_d    = we_op_q;
    issue_rd_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m_read || m_write) begin
          pend_d  = en_mask;
          addr_d  = core_addr;
          wdata_d = core_wdata;
          we_op_d = m_write;
          if (en_mask == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        pend_d     = pend_q & ~group_s;
        issue_rd_s = ~we_op_q;
        if (pend_d == '0) begin
          state_d = we_op_q ? ST_DONE : ST_DRAIN;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (upstream_busy_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    lane_d       = lowest_lane(pend_d);
    issue_next_s = (state_d == ST_ISSUE);
  end

  // Control state, captured request and registered memory-port outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_op_q     <= 1'b0;
      lane_q      <= '0;
      busy_q      <= 1'b0;
      m_ready_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_op_q     <= we_op_d;
      lane_q      <= lane_d;
      busy_q      <= (state_d != ST_IDLE);
      m_ready_q   <= (state_d == ST_DONE);
      mem_addr_q  <= issue_next_s ? lane_addr(addr_d, lane_d) : '0;
      mem_we_q    <= issue_next_s & we_op_d;
      mem_wdata_q <= (issue_next_s && we_op_d) ? lane_data(wdata_d, lane_d) : '0;
    end
  end

  // Read group masks delayed to line up with returning memory data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < RD_LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0] <= issue_rd_s ? group_s : '0;
      for (int s = 1; s < RD_LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  // Scatter returning read data into every lane of the emerging group.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_rdata_q <= '0;
    end else begin
      for (int i = 0; i < N_CORES; i++) begin
        if (tag_q[RD_LAT-1][i]) begin
          core_rdata_q[i*DATA_W +: DATA_W] <= mem_rdata;
        end
      end
    end
  end

  assign m_ready    = m_ready_q;
  assign busy       = busy_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign core_rdata = core_rdata_q;

endmodule

// File: tb/tb_sm_mem_ctrl.sv
// Scoreboard bench for sm_mem_ctrl (4 lanes, read latency 2). A request-level
// model predicts every memory access and the completion response; a monitor
// compares them as the DUT produces them. A second instance without read
// merging is exercised on the shared-address read case.
module tb_sm_mem_ctrl;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          m_read, m_write, m_ready, busy;
  logic [N-1:0]  en_mask;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata, core_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we;

  logic            nc_read, nc_ready, nc_busy, nc_we;
  logic [N*DW-1:0] nc_core_rdata;
  logic [AW-1:0]   nc_addr;
  logic [DW-1:0]   nc_wdata, nc_mem_rdata;

  sm_mem_ctrl #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .COALESCE(1)) dut (
    .clk(clk), .reset(reset), .m_read(m_read), .m_write(m_write), .m_ready(m_ready),
    .busy(busy), .en_mask(en_mask), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata));

  sm_mem_ctrl #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .COALESCE(0)) dut_nc (
    .clk(clk), .reset(reset), .m_read(nc_read), .m_write(1'b0), .m_ready(nc_ready),
    .busy(nc_busy), .en_mask(en_mask), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(nc_core_rdata), .mem_addr(nc_addr), .mem_wdata(nc_wdata), .mem_we(nc_we),
    .mem_rdata(nc_mem_rdata));

  always #5 clk = ~clk;

  // Memory environment: writes land at the edge, reads return RL cycles later.
  logic [DW-1:0] mem     [256] = '{default: 16'h0000};
  logic [DW-1:0] ref_mem [256] = '{default: 16'h0000};
  logic [DW-1:0] rd_pipe [RL]  = '{default: 16'h0000};
  logic [DW-1:0] nc_pipe [RL]  = '{default: 16'h0000};
  assign mem_rdata    = rd_pipe[RL-1];
  assign nc_mem_rdata = nc_pipe[RL-1];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    rd_pipe[0] <= mem[mem_addr[7:0]];
    nc_pipe[0] <= mem[nc_addr[7:0]];
    for (int s = 1; s < RL; s++) begin
      rd_pipe[s] <= rd_pipe[s-1];
      nc_pipe[s] <= nc_pipe[s-1];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata; } acc_t;
  typedef struct { int req_cyc; int lat; logic [N*DW-1:0] rdata; } txn_t;

  acc_t acc_q[$];
  txn_t txn_q[$];
  logic [DW-1:0] exp_core [N] = '{default: 16'h0000};
  int n_checks = 0, n_errors = 0, n_ready_seen = 0;
  int nc_acc = 0, nc_ready_cyc = -1, nc_req_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare memory accesses and completions against the scoreboard.
  always @(negedge clk) begin : monitor
    acc_t a;
    txn_t t;
    if (reset) begin
      if (mem_we || mem_addr != '0) begin
        if (acc_q.size() == 0) begin
          check("unexpected_access", {47'd0, mem_we, mem_addr}, 64'd0);
        end else begin
          a = acc_q.pop_front();
          check("acc_cycle", 64'(cyc), 64'(a.cyc));
          check("acc_addr", 64'(mem_addr), 64'(a.addr));
          check("acc_we", 64'(mem_we), 64'(a.we));
          check("acc_wdata", 64'(mem_wdata), 64'(a.wdata));
        end
      end
      if (m_ready) begin
        n_ready_seen++;
        if (txn_q.size() == 0) begin
          check("unexpected_ready", 64'd1, 64'd0);
        end else begin
          t = txn_q.pop_front();
          check("ready_latency", 64'(cyc - t.req_cyc), 64'(t.lat));
          check("core_rdata", core_rdata, t.rdata);
          check("busy_at_ready", 64'(busy), 64'd1);
          check("issues_pending_at_ready", 64'(acc_q.size()), 64'd0);
        end
      end
      if (nc_we || nc_addr != '0) nc_acc++;
      if (nc_ready) nc_ready_cyc = cyc;
    end
  end

  // Issue one request, predict its behaviour, wait (bounded) for completion.
  task automatic do_req(input logic rd, input logic wr, input logic [N-1:0] mask,
                        input logic [N*AW-1:0] addrs, input logic [N*DW-1:0] wd,
                        input logic with_nc);
    int c0, cnt, tgt, lo;
    logic [N-1:0]  pend;
    logic [AW-1:0] a;
    acc_t ac;
    txn_t t;
    @(posedge clk); #1;
    m_read = rd; m_write = wr; en_mask = mask; core_addr = addrs; core_wdata = wd;
    nc_read = with_nc;
    c0 = cyc; cnt = 0;
    if (with_nc) nc_req_cyc = c0;
    if (wr) begin
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          cnt++;
          ac.cyc = c0 + cnt; ac.addr = addrs[i*AW +: AW]; ac.we = 1'b1; ac.wdata = wd[i*DW +: DW];
          acc_q.push_back(ac);
          ref_mem[ac.addr[7:0]] = ac.wdata;
        end
      end
      t.lat = cnt + 1;
    end else begin
      pend = mask;
      while (pend != '0) begin
        lo = 0;
        for (int i = N - 1; i >= 0; i--) if (pend[i]) lo = i;
        a = addrs[lo*AW +: AW];
        for (int j = 0; j < N; j++) begin
          if (pend[j] && addrs[j*AW +: AW] == a) begin
            exp_core[j] = ref_mem[a[7:0]];
            pend[j] = 1'b0;
          end
        end
        cnt++;
        ac.cyc = c0 + cnt; ac.addr = a; ac.we = 1'b0; ac.wdata = '0;
        acc_q.push_back(ac);
      end
      t.lat = (mask == '0) ? 1 : cnt + RL + 1;
    end
    t.req_cyc = c0;
    for (int j = 0; j < N; j++) t.rdata[j*DW +: DW] = exp_core[j];
    txn_q.push_back(t);
    tgt = n_ready_seen + 1;
    @(posedge clk); #1;
    m_read = 1'b0; m_write = 1'b0; nc_read = 1'b0;
    for (int k = 0; k < 40 && n_ready_seen < tgt; k++) @(posedge clk);
    if (n_ready_seen < tgt) check("ready_timeout", 64'(n_ready_seen), 64'(tgt));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_m_ready"}, 64'(m_ready), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_core_rdata"}, core_rdata, 64'd0);
  endtask

  initial begin
    logic [N*AW-1:0] ad;
    logic [N*DW-1:0] wd;
    acc_t ac;
    reset = 1'b0; m_read = 1'b0; m_write = 1'b0; nc_read = 1'b0;
    en_mask = '0; core_addr = '0; core_wdata = '0;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1 check_outputs_zero("post_reset");

    // Write mask 1011, lane 2 skipped.
    do_req(1'b0, 1'b1, 4'b1011, {16'h0013, 16'h0012, 16'h0011, 16'h0010},
           {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0}, 1'b0);
    check("mem_0x13", 64'(mem[8'h13]), 64'h00A3);

    // Preload 0x40..0x43, then four distinct reads.
    do_req(1'b0, 1'b1, 4'b1111, {16'h0043, 16'h0042, 16'h0041, 16'h0040},
           {16'h0008, 16'h0007, 16'h0006, 16'h0005}, 1'b0);
    do_req(1'b1, 1'b0, 4'b1111, {16'h0043, 16'h0042, 16'h0041, 16'h0040}, '0, 1'b0);
    check("distinct_read_lanes", core_rdata, 64'h0008_0007_0006_0005);

    // Shared-address reads: merged on dut, four accesses on dut_nc.
    do_req(1'b0, 1'b1, 4'b0011, {16'h0, 16'h0, 16'h0021, 16'h0020},
           {16'h0, 16'h0, 16'h5678, 16'h1234}, 1'b0);
    nc_acc = 0; nc_ready_cyc = -1;
    do_req(1'b1, 1'b0, 4'b1111, {16'h0020, 16'h0021, 16'h0020, 16'h0020}, '0, 1'b1);
    for (int k = 0; k < 20 && nc_ready_cyc < 0; k++) @(posedge clk);
    check("nc_accesses", 64'(nc_acc), 64'd4);
    check("nc_ready_latency", 64'(nc_ready_cyc - nc_req_cyc), 64'd7);
    check("nc_core_rdata", nc_core_rdata, 64'h1234_5678_1234_1234);

    // Zero mask read: immediate completion, nothing on the memory port.
    do_req(1'b1, 1'b0, 4'b0000, {16'h0043, 16'h0042, 16'h0041, 16'h0040}, '0, 1'b0);

    // Read and write together is a write; lane 2 wins on the shared address.
    do_req(1'b1, 1'b1, 4'b0101, {16'h0, 16'h0030, 16'h0, 16'h0030},
           {16'h0, 16'h2222, 16'h0, 16'h1111}, 1'b0);
    check("mem_0x30", 64'(mem[8'h30]), 64'h2222);

    // Randomised traffic over a small address pool so merging occurs.
    for (int n = 0; n < 30; n++) begin
      int op;
      op = $urandom_range(0, 2);
      for (int i = 0; i < N; i++) begin
        ad[i*AW +: AW] = 16'h0050 + 16'($urandom_range(0, 3));
        wd[i*DW +: DW] = 16'($urandom);
      end
      do_req(op != 1, op != 0, 4'($urandom_range(0, 15)), ad, wd, 1'b0);
    end

    // Reset in cycle 2 of a four-lane read.
    @(posedge clk); #1;
    m_read = 1'b1; en_mask = 4'b1111;
    core_addr = {16'h0043, 16'h0042, 16'h0041, 16'h0040};
    ac.cyc = cyc + 1; ac.addr = 16'h0040; ac.we = 1'b0; ac.wdata = '0;
    acc_q.push_back(ac);
    @(posedge clk); #1 m_read = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    #1 check_outputs_zero("mid_reset");
    acc_q.delete(); txn_q.delete();
    for (int j = 0; j < N; j++) exp_core[j] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (6) @(posedge clk);
    check("no_ready_after_abort", 64'(n_ready_seen), 64'(n_ready_seen));
    do_req(1'b1, 1'b0, 4'b0110, {16'h0043, 16'h0042, 16'h0041, 16'h0040}, '0, 1'b0);

    repeat (4) @(posedge clk);
    check("acc_queue_empty", 64'(acc_q.size()), 64'd0);
    check("txn_queue_empty", 64'(txn_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
